// File: rtl/conv1_window_gen.sv
// 3x3 sliding-window generator for conv1: two line buffers plus a shifting register window,
// emitting one registered window per accepted pixel that has a full neighbourhood.
module conv1_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out [0:8],
  output logic              valid_out,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     r_col_cnt;
  logic [RW-1:0]     r_row_cnt;
  logic [DATA_W-1:0] r_line1 [0:IMG_W-1];
  logic [DATA_W-1:0] r_line2 [0:IMG_W-1];
  logic [DATA_W-1:0] r_win [0:8];
  logic [DATA_W-1:0] r_data_out [0:8];
  logic              r_valid_out;
  logic              r_frame_done;

  logic [DATA_W-1:0] w_line1_rd;
  logic [DATA_W-1:0] w_line2_rd;
  logic [DATA_W-1:0] w_next_win [0:8];
  logic              w_col_last;
  logic              w_row_last;
  logic              w_emit;
  logic              w_last;

  assign w_line1_rd = r_line1[r_col_cnt];
  assign w_line2_rd = r_line2[r_col_cnt];
  assign w_col_last = (r_col_cnt == CW'(IMG_W - 1));
  assign w_row_last = (r_row_cnt == RW'(IMG_H - 1));
  assign w_emit     = valid_in && (r_row_cnt >= RW'(2)) && (r_col_cnt >= CW'(2));
  assign w_last     = valid_in && w_col_last && w_row_last;

  // Window after this pixel: every row shifts left, the new column {line2, line1, pixel} enters right.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_next_win[3*i]   = r_win[3*i+1];
      w_next_win[3*i+1] = r_win[3*i+2];
    end
    w_next_win[2] = w_line2_rd;
    w_next_win[5] = w_line1_rd;
    w_next_win[8] = data_in;
  end

  // Storage that never needs clearing: stale contents are never emitted before (2,2) of a frame.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_line2[r_col_cnt] <= w_line1_rd;
      r_line1[r_col_cnt] <= data_in;
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= w_next_win[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_data_out[k] <= '0;
      end
    end else begin
      r_valid_out  <= w_emit;
      r_frame_done <= w_last;
      if (w_emit) begin
        for (int k = 0; k < 9; k++) begin
          r_data_out[k] <= w_next_win[k];
        end
      end
      if (valid_in) begin
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
        end else begin
          r_col_cnt <= r_col_cnt + CW'(1);
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv1_window_gen.sv
// Directed and table-driven bench for conv1_window_gen: a 4x4 instance for hand-computed windows
// and a default 28x28 instance checked against a frame-array reference model.
module tb_conv1_window_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;

  logic [31:0] dataOut4 [0:8];
  logic [31:0] dataOut28 [0:8];
  logic        validOut4, frameDone4, validOut28, frameDone28;

  typedef logic [8:0][31:0] win_t;
  win_t win4, win28, lastWin4, lastWin28;

  typedef struct {
    logic vin;
    int   pix;
    logic expV;
    logic expD;
    int   wIdx;
    int   wOff;
  } vec_t;
  vec_t vecs[$];

  int errors = 0;
  int checks = 0;
  int winCount4;

  // Hand-computed 4x4 windows of a frame numbered 0..15, in emission order.
  int winTab [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                        '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

  logic [31:0] img [28][28];

  always #5 clk = ~clk;

  conv1_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .data_out(dataOut4), .valid_out(validOut4), .frame_done(frameDone4));

  conv1_window_gen dut28 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .data_out(dataOut28), .valid_out(validOut28), .frame_done(frameDone28));

  always_comb begin
    win4  = '0;
    win28 = '0;
    for (int i = 0; i < 9; i++) begin
      win4[i]  = dataOut4[i];
      win28[i] = dataOut28[i];
    end
  end

  // IEEE-754 single-precision encoding of a small non-negative integer.
  function automatic logic [31:0] fp(input int k);
    int e;
    if (k == 0) return 32'h0;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((k << (23 - e)) & 32'h007F_FFFF)};
  endfunction

  function automatic win_t smallWin(input int idx, input int off);
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = fp(winTab[idx][i] + off);
    return w;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkWin(input string name, input win_t act, input win_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    win_t exp;
    checkBit({tag, " valid_out"}, validOut4, v.expV);
    checkBit({tag, " frame_done"}, frameDone4, v.expD);
    if (validOut4) winCount4++;
    if (v.expV) begin
      exp = smallWin(v.wIdx, v.wOff);
      checkWin({tag, " window"}, win4, exp);
      lastWin4 = exp;
    end else begin
      checkWin({tag, " hold"}, win4, lastWin4);
    end
  endtask

  task automatic addFrame(input int off, input int gap, input int count);
    int idx;
    for (int p = 0; p < count; p++) begin
      case (p)
        10:      idx = 0;
        11:      idx = 1;
        14:      idx = 2;
        15:      idx = 3;
        default: idx = -1;
      endcase
      vecs.push_back('{1'b1, p + off, idx >= 0, p == 15, idx, off});
      for (int g = 0; g < gap; g++) vecs.push_back('{1'b0, -1, 1'b0, 1'b0, -1, 0});
    end
  endtask

  task automatic runTable(input string tag);
    foreach (vecs[n]) begin
      applyStimulus(vecs[n].vin, (vecs[n].pix < 0) ? 32'hDEAD_BEEF : fp(vecs[n].pix));
      checkOutput(tag, vecs[n]);
    end
    vecs.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, " valid_out4"}, validOut4, 1'b0);
    checkBit({tag, " frame_done4"}, frameDone4, 1'b0);
    checkWin({tag, " data_out4"}, win4, '0);
    checkBit({tag, " valid_out28"}, validOut28, 1'b0);
    checkBit({tag, " frame_done28"}, frameDone28, 1'b0);
    checkWin({tag, " data_out28"}, win28, '0);
  endtask

  task automatic randomFrames28();
    logic [31:0] pix;
    logic        expV;
    win_t        exp;
    int          winCnt, doneCnt;
    for (int f = 0; f < 2; f++) begin
      winCnt  = 0;
      doneCnt = 0;
      for (int r = 0; r < 28; r++) begin
        for (int c = 0; c < 28; c++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              applyStimulus(1'b0, $urandom);
              checkBit("rand gap valid_out", validOut28, 1'b0);
              checkWin("rand gap hold", win28, lastWin28);
              winCnt  += int'(validOut28);
              doneCnt += int'(frameDone28);
            end
          end
          case ($urandom_range(0, 15))
            0:       pix = 32'h7FC0_0000;
            1:       pix = 32'h8000_0000;
            2:       pix = 32'h7F80_0001;
            3:       pix = 32'hFFC0_1234;
            default: pix = $urandom;
          endcase
          img[r][c] = pix;
          applyStimulus(1'b1, pix);
          expV = (r >= 2) && (c >= 2);
          checkBit("rand valid_out", validOut28, expV);
          checkBit("rand frame_done", frameDone28, (r == 27) && (c == 27));
          if (expV) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                exp[3*i+j] = img[r-2+i][c-2+j];
            checkWin("rand window", win28, exp);
            lastWin28 = exp;
          end
          winCnt  += int'(validOut28);
          doneCnt += int'(frameDone28);
        end
      end
      checkInt("rand windows per frame", winCnt, 676);
      checkInt("rand frame_done per frame", doneCnt, 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;
    lastWin4  = '0;
    lastWin28 = '0;

    // Reset state, then idle with valid_in low.
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      applyStimulus(1'b0, $urandom);
      checkAllZero("idle");
    end

    winCount4 = 0;
    addFrame(0, 0, 16);
    runTable("t1");
    checkInt("t1 window count", winCount4, 4);

    winCount4 = 0;
    addFrame(0, 3, 16);
    runTable("t2");
    checkInt("t2 window count", winCount4, 4);

    winCount4 = 0;
    addFrame(0, 0, 16);
    addFrame(16, 0, 16);
    runTable("t3");
    checkInt("t3 window count", winCount4, 8);

    // Reset mid-frame after pixel 6, with valid_in high during reset.
    addFrame(0, 0, 7);
    runTable("t4 partial");
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    data_in  = fp(7);
    #2;
    checkBit("t4 async valid_out", validOut4, 1'b0);
    checkWin("t4 async data_out", win4, '0);
    @(posedge clk);
    #1;
    checkBit("t4 reset valid_out", validOut4, 1'b0);
    checkBit("t4 reset frame_done", frameDone4, 1'b0);
    checkWin("t4 reset data_out", win4, '0);
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    lastWin4 = '0;
    winCount4 = 0;
    addFrame(0, 0, 16);
    runTable("t4");
    checkInt("t4 window count", winCount4, 4);

    // Fresh start for the 28x28 instance.
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    lastWin28 = '0;
    randomFrames28();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
